// File: rtl/parking_fee_calc.sv
// rtl/parking_fee_calc.sv - parking fee from a BCD HHMM duration, two-digit BCD result
//
// Purpose: on an exit strobe, capture the BCD HHMM parking duration. Validate it,
// convert it to minutes, round up to started hours, multiply by the hourly rate,
// saturate the product and convert it to two BCD digits. The result is then held
// under a valid/ack handshake.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   exit_strobe    1-cycle pulse, parking_timer sampled on this cycle when idle
//   parking_timer  BCD {hours_tens, hours_ones, minutes_tens, minutes_ones}
//   fee_valid      fee_bcd/bad_input valid, held until fee_ack
//   fee_ack        consumer accepts the result
//   fee_bcd        {fee_tens, fee_ones} BCD
//   bad_input      captured duration was not legal BCD HHMM
//   busy           calculation in progress or result pending ack
//   overrun        exit_strobe seen while busy (same cycle, combinational)

module parking_fee_calc #(
  parameter int RATE_PER_HOUR = 5,
  parameter int GRACE_MIN     = 15,
  parameter int MAX_FEE       = 99
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exit_strobe,
  input  logic [15:0] parking_timer,
  output logic        fee_valid,
  input  logic        fee_ack,
  output logic [7:0]  fee_bcd,
  output logic        bad_input,
  output logic        busy,
  output logic        overrun
);

  localparam logic [11:0] RATE12  = 12'(RATE_PER_HOUR);
  localparam logic [11:0] MAX12   = 12'(MAX_FEE);
  localparam logic [10:0] GRACE11 = 11'(GRACE_MIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MINUTES,
    S_HOURS,
    S_MULT,
    S_BCD,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [10:0] rem_q, rem_d;      // minutes left to divide into hours
  logic [4:0]  hrs_q, hrs_d;      // started hours, 1..24
  logic [4:0]  cnt_q, cnt_d;      // additions done so far
  logic [11:0] acc_q, acc_d;      // product, later reused as the ones remainder
  logic [3:0]  tens_q, tens_d;
  logic [7:0]  fee_bcd_q, fee_bcd_d;
  logic        bad_q, bad_d;

  logic [3:0]  ht, ho, mt, mo;
  logic        legal;
  logic [10:0] hours11;
  logic [10:0] total;
  logic [11:0] sum;
  logic [4:0]  cnt_next;

  assign ht = timer_q[15:12];
  assign ho = timer_q[11:8];
  assign mt = timer_q[7:4];
  assign mo = timer_q[3:0];

  always_comb begin
    legal    = (ht <= 4'd2) && (ho <= 4'd9) && !((ht == 4'd2) && (ho > 4'd3)) &&
               (mt <= 4'd5) && (mo <= 4'd9);
    hours11  = 11'(ht) * 11'd10 + 11'(ho);
    total    = hours11 * 11'd60 + 11'(mt) * 11'd10 + 11'(mo);
    sum      = acc_q + RATE12;
    cnt_next = cnt_q + 5'd1;
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rem_d     = rem_q;
    hrs_d     = hrs_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    tens_d    = tens_q;
    fee_bcd_d = fee_bcd_q;
    bad_d     = bad_q;

    unique case (state_q)
      S_IDLE: begin
        if (exit_strobe) begin
          timer_d = parking_timer;
          bad_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!legal) begin
          bad_d     = 1'b1;
          fee_bcd_d = 8'h00;
          state_d   = S_DONE;
        end else begin
          state_d = S_MINUTES;
        end
      end
      S_MINUTES: begin
        if (total <= GRACE11) begin
          fee_bcd_d = 8'h00;
          state_d   = S_DONE;
        end else begin
          rem_d   = total;
          hrs_d   = 5'd0;
          state_d = S_HOURS;
        end
      end
      S_HOURS: begin
        // Each pass accounts for one hour. A remainder of 1..60 is the last
        // started hour, so exact multiples of 60 do not round up.
        hrs_d = hrs_q + 5'd1;
        if (rem_q > 11'd60) begin
          rem_d = rem_q - 11'd60;
        end else begin
          acc_d   = 12'd0;
          cnt_d   = 5'd0;
          state_d = S_MULT;
        end
      end
      S_MULT: begin
        // Saturation ends the loop early, so acc never exceeds MAX_FEE.
        tens_d = 4'd0;
        if (sum >= MAX12) begin
          acc_d   = MAX12;
          state_d = S_BCD;
        end else begin
          acc_d = sum;
          cnt_d = cnt_next;
          if (cnt_next == hrs_q) begin
            state_d = S_BCD;
          end
        end
      end
      S_BCD: begin
        if (acc_q >= 12'd10) begin
          acc_d  = acc_q - 12'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          fee_bcd_d = {tens_q, acc_q[3:0]};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (fee_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= 16'h0000;
      rem_q     <= 11'd0;
      hrs_q     <= 5'd0;
      cnt_q     <= 5'd0;
      acc_q     <= 12'd0;
      tens_q    <= 4'd0;
      fee_bcd_q <= 8'h00;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rem_q     <= rem_d;
      hrs_q     <= hrs_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      tens_q    <= tens_d;
      fee_bcd_q <= fee_bcd_d;
      bad_q     <= bad_d;
    end
  end

  assign fee_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign overrun   = exit_strobe & busy;
  assign fee_bcd   = fee_bcd_q;
  assign bad_input = bad_q;

endmodule
